physics_integrator: RTL

- Hardware physics-step engine for the renderer's scene update: per frame, advances up to N_OBJ objects by one timestep dt.
- Per object: position += velocity*dt; optional gravity on velocity; rotation = rotation ⊗ angular-velocity quaternion.
- Generalised successor of the software physics step: fixed-point, parametrised object count and word width, mode-selectable, saturating, sweep with start/busy/done handshake.
- Sits between the host/scene loader (which writes object state) and the transform stage (which reads it back).

---
 rtl/phys_pkg.sv | 75 +++++++
 rtl/physics_integrator_if.sv | 26 ++
 rtl/quat_mul.sv | 36 +++
 rtl/physics_integrator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/phys_pkg.sv
// Shared fixed-point types, constants and arithmetic helpers for the physics step engine.
// All words are signed Q16.16; the host bus packs quaternions as {w,z,y,x}.
package phys_pkg;

  localparam int FX_W    = 32;
  localparam int FX_FRAC = 16;

  typedef logic signed [FX_W-1:0]   fx_t;
  typedef logic signed [2*FX_W:0]   wide_t;
  typedef logic signed [FX_W+1:0]   sum_t;

  typedef struct packed {
    fx_t z;
    fx_t y;
    fx_t x;
  } vec3_t;

  typedef struct packed {
    fx_t w;
    fx_t z;
    fx_t y;
    fx_t x;
  } quat_t;

  typedef enum logic [1:0] {
    FIELD_POS    = 2'd0,
    FIELD_VEL    = 2'd1,
    FIELD_ROT    = 2'd2,
    FIELD_ANGVEL = 2'd3
  } field_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_STORE = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  localparam fx_t   Q_ONE         = fx_t'(1) <<< FX_FRAC;
  localparam fx_t   FX_MAX        = {1'b0, {(FX_W-1){1'b1}}};
  localparam fx_t   FX_MIN        = {1'b1, {(FX_W-1){1'b0}}};
  localparam quat_t QUAT_IDENTITY = '{w: Q_ONE, z: '0, y: '0, x: '0};

  function automatic wide_t sext(input fx_t a);
    return {{(FX_W+1){a[FX_W-1]}}, a};
  endfunction

  // Value fits in a word when every bit above the word's sign bit matches it.
  function automatic fx_t sat(input wide_t v);
    if (v[2*FX_W:FX_W-1] == '0 || v[2*FX_W:FX_W-1] == '1) return v[FX_W-1:0];
    else if (v[2*FX_W]) return FX_MIN;
    else return FX_MAX;
  endfunction

  // Full 2W-bit product, arithmetic shift floors toward -inf.
  function automatic wide_t fxmul(input fx_t a, input fx_t b);
    logic signed [2*FX_W-1:0] p;
    wide_t e;
    p = a * b;
    e = {p[2*FX_W-1], p};
    return e >>> FX_FRAC;
  endfunction

  function automatic sum_t pp(input fx_t a, input fx_t b);
    wide_t m;
    m = fxmul(a, b);
    return m[FX_W+1:0];
  endfunction

  function automatic fx_t sat_sum(input sum_t s);
    return sat({{(FX_W-1){s[FX_W+1]}}, s});
  endfunction

endpackage

// File: rtl/physics_integrator_if.sv
// Host access bus: field writes and one-cycle-latency field reads of the object array.
// Handshake: a write or read is taken on any edge where its enable is high (no ready);
// host_rvalid marks the cycle host_rdata is valid, host_wr_err marks a dropped write.
interface physics_integrator_if #(
  parameter int W     = 32,
  parameter int IDX_W = 4
);
  logic             host_wr_en;
  logic             host_rd_en;
  logic [IDX_W-1:0] host_idx;
  logic [1:0]       host_field;
  logic [4*W-1:0]   host_wdata;
  logic [4*W-1:0]   host_rdata;
  logic             host_rvalid;
  logic             host_wr_err;

  modport master (
    output host_wr_en, host_rd_en, host_idx, host_field, host_wdata,
    input  host_rdata, host_rvalid, host_wr_err
  );

  modport slave (
    input  host_wr_en, host_rd_en, host_idx, host_field, host_wdata,
    output host_rdata, host_rvalid, host_wr_err
  );
endinterface

// File: rtl/quat_mul.sv
// Pipelined Hamilton product p = a (x) b with a fixed QLAT-cycle latency and no handshake.
// Partial products are truncated to W+2 bits, summed there, then saturated to W.
module quat_mul
  import phys_pkg::*;
#(
  parameter int QLAT = 2
) (
  input  logic  clk,
  input  quat_t a,
  input  quat_t b,
  output quat_t p
);

  quat_t prod_d;
  quat_t pipe_q [QLAT];
  sum_t  sw, sx, sy, sz;

  always_comb begin
    sw = pp(a.w, b.w) - pp(a.x, b.x) - pp(a.y, b.y) - pp(a.z, b.z);
    sx = pp(a.w, b.x) + pp(a.x, b.w) + pp(a.y, b.z) - pp(a.z, b.y);
    sy = pp(a.w, b.y) - pp(a.x, b.z) + pp(a.y, b.w) + pp(a.z, b.x);
    sz = pp(a.w, b.z) + pp(a.x, b.y) - pp(a.y, b.x) + pp(a.z, b.w);
    prod_d.w = sat_sum(sw);
    prod_d.x = sat_sum(sx);
    prod_d.y = sat_sum(sy);
    prod_d.z = sat_sum(sz);
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= prod_d;
    for (int k = 1; k < QLAT; k++) pipe_q[k] <= pipe_q[k-1];
  end

  assign p = pipe_q[QLAT-1];

endmodule

// File: rtl/physics_integrator.sv
// Per-frame physics sweep: explicit-Euler position, optional gravity, and rotation by
// angular-velocity quaternion over objects 0..n_active-1, with host field access when idle.
module physics_integrator
  import phys_pkg::*;
#(
  parameter int  N_OBJ = 16,
  parameter int  W     = FX_W,
  parameter int  QLAT  = 2,
  parameter fx_t GRAV  = -32'sd642252,
  parameter int  IDX_W = $clog2(N_OBJ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [W-1:0]  dt,
  input  logic [1:0]           mode,
  input  logic [IDX_W:0]       n_active,
  output logic                 busy,
  output logic                 done,
  physics_integrator_if.slave  host,
  output state_e               dbg_state
);

  localparam int             CNT_W    = (QLAT > 1) ? $clog2(QLAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QLAT-1);
  localparam logic [IDX_W:0] N_MAX    = (IDX_W+1)'(N_OBJ);

  state_e               state_q, state_d;
  fx_t                  dt_q, dt_d;
  logic [1:0]           mode_q, mode_d;
  logic [IDX_W:0]       n_q, n_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  vec3_t                wpos_q, wpos_d, wvel_q, wvel_d;
  logic                 done_q, done_d;
  logic                 wr_err_q, wr_err_d;
  logic                 rvalid_q, rvalid_d;
  logic [4*W-1:0]       rdata_q, rdata_d;

  vec3_t pos_q [N_OBJ];
  vec3_t pos_d [N_OBJ];
  vec3_t vel_q [N_OBJ];
  vec3_t vel_d [N_OBJ];
  quat_t rot_q [N_OBJ];
  quat_t rot_d [N_OBJ];
  quat_t angvel_q [N_OBJ];
  quat_t angvel_d [N_OBJ];

  quat_t mul_out;
  quat_t wq;
  vec3_t wv;
  vec3_t pos_new, vel_new;

  // Multiplier inputs come straight from the array; host writes are blocked while busy,
  // so the output is stable from the last CALC cycle through STORE.
  quat_mul #(.QLAT(QLAT)) u_quat_mul (
    .clk (clk),
    .a   (rot_q[idx_q]),
    .b   (angvel_q[idx_q]),
    .p   (mul_out)
  );

  assign wq = host.host_wdata;
  assign wv = '{z: wq.z, y: wq.y, x: wq.x};

  always_comb begin
    pos_new.x = sat(sext(wpos_q.x) + fxmul(wvel_q.x, dt_q));
    pos_new.y = sat(sext(wpos_q.y) + fxmul(wvel_q.y, dt_q));
    pos_new.z = sat(sext(wpos_q.z) + fxmul(wvel_q.z, dt_q));
    vel_new   = wvel_q;
    if (mode_q[1]) vel_new.y = sat(sext(wvel_q.y) + fxmul(GRAV, dt_q));
  end

  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    mode_d  = mode_q;
    n_d     = n_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wpos_d  = wpos_q;
    wvel_d  = wvel_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dt_d    = dt;
          mode_d  = mode;
          n_d     = (n_active > N_MAX) ? N_MAX : n_active;
          idx_d   = '0;
          state_d = (n_active == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        wpos_d  = pos_q[idx_q];
        wvel_d  = vel_q[idx_q];
        cnt_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (cnt_q == CNT_LAST) state_d = S_STORE;
        else cnt_d = cnt_q + 1'b1;
      end
      S_STORE: begin
        if ({1'b0, idx_q} == n_q - 1'b1) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pos_d    = pos_q;
    vel_d    = vel_q;
    rot_d    = rot_q;
    angvel_d = angvel_q;
    if (host.host_wr_en && state_q == S_IDLE) begin
      unique case (field_e'(host.host_field))
        FIELD_POS:    pos_d[host.host_idx]    = wv;
        FIELD_VEL:    vel_d[host.host_idx]    = wv;
        FIELD_ROT:    rot_d[host.host_idx]    = wq;
        FIELD_ANGVEL: angvel_d[host.host_idx] = wq;
      endcase
    end
    if (state_q == S_STORE) begin
      pos_d[idx_q] = pos_new;
      vel_d[idx_q] = vel_new;
      if (mode_q[0]) rot_d[idx_q] = mul_out;
    end
  end

  // Reads see the array as committed before this edge's write.
  always_comb begin
    wr_err_d = host.host_wr_en && (state_q != S_IDLE);
    rvalid_d = host.host_rd_en;
    rdata_d  = rdata_q;
    if (host.host_rd_en) begin
      unique case (field_e'(host.host_field))
        FIELD_POS:    rdata_d = {{FX_W{1'b0}}, pos_q[host.host_idx]};
        FIELD_VEL:    rdata_d = {{FX_W{1'b0}}, vel_q[host.host_idx]};
        FIELD_ROT:    rdata_d = rot_q[host.host_idx];
        FIELD_ANGVEL: rdata_d = angvel_q[host.host_idx];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dt_q     <= '0;
      mode_q   <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      wpos_q   <= '0;
      wvel_q   <= '0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int k = 0; k < N_OBJ; k++) begin
        pos_q[k]    <= '0;
        vel_q[k]    <= '0;
        rot_q[k]    <= QUAT_IDENTITY;
        angvel_q[k] <= QUAT_IDENTITY;
      end
    end else begin
      state_q  <= state_d;
      dt_q     <= dt_d;
      mode_q   <= mode_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wpos_q   <= wpos_d;
      wvel_q   <= wvel_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      pos_q    <= pos_d;
      vel_q    <= vel_d;
      rot_q    <= rot_d;
      angvel_q <= angvel_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign done             = done_q;
  assign dbg_state        = state_q;
  assign host.host_rdata  = rdata_q;
  assign host.host_rvalid = rvalid_q;
  assign host.host_wr_err = wr_err_q;

endmodule
